// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default constants for the scoreboarded register file.
//   XLEN_D     - default data width
//   NREGS_D    - default register count
//   MAX_PEND_D - default maximum outstanding reservations per register
package regfile_pkg;
  localparam int XLEN_D     = 32;
  localparam int NREGS_D    = 32;
  localparam int MAX_PEND_D = 3;
endpackage

// File: rtl/rf_pend_cnt.sv
// rf_pend_cnt: pending-write counter for one scoreboarded register.
// Ports:
//   i_clk  - clock, rising edge
//   i_rstn - asynchronous active-low reset
//   i_inc  - accepted reservation (caller guarantees counter < MAX_PEND or i_dec)
//   i_dec  - retiring writeback (caller guarantees counter != 0)
//   i_clr  - flush; forces the counter to 0 and overrides inc/dec
//   o_cnt  - current count
module rf_pend_cnt #(
  parameter int MAX_PEND = 3,
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_cnt = r_cnt;

  // The gating upstream must never let the counter wrap in either direction.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(i_inc && !i_dec && !i_clr && (r_cnt == CW'(MAX_PEND))));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(i_dec && !i_inc && !i_clr && (r_cnt == '0)));

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded GPR bank.
// NRD combinational read ports, one synchronous writeback port, optional
// write-through bypass of data and busy state, and a per-register pending
// counter that is incremented at issue (reservation) and decremented at
// writeback. x0 reads as zero, is never written and is never busy.
// Ports:
//   i_clk, i_rstn        - clock / asynchronous active-low reset
//   i_rd_wren/addr/data  - writeback port
//   i_rsv_en/addr        - reservation request; o_rsv_ready = accepted this cycle
//   i_flush              - clear all pending counters
//   i_rs_addr            - packed read addresses, port k at [k*AW +: AW]
//   o_rs_data            - packed read data, port k at [k*XLEN +: XLEN]
//   o_rs_busy            - per-port operand-has-outstanding-writes flag
//   o_any_busy           - some register has a nonzero counter
//   o_sb_err             - sticky: writeback arrived with counter 0
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_D,
  parameter int NREGS     = NREGS_D,
  parameter int NRD       = 2,
  parameter int MAX_PEND  = MAX_PEND_D,
  parameter bit BYPASS_EN = 1'b1,
  parameter int AW        = $clog2(NREGS),
  parameter int CW        = $clog2(MAX_PEND + 1)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_rd_wren,
  input  logic [AW-1:0]       i_rd_addr,
  input  logic [XLEN-1:0]     i_rd_data,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  output logic                o_rsv_ready,
  input  logic                i_flush,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  output logic                o_any_busy,
  output logic                o_sb_err
);

  logic [XLEN-1:0]  r_data [NREGS];
  logic [CW-1:0]    w_cnt  [NREGS];
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic [NREGS-1:0] w_nz;
  logic             r_sb_err;
  logic             w_wr_valid;
  logic             w_underflow;

  assign w_wr_valid = i_rd_wren && (i_rd_addr != '0);

  // ---------------- data bank ----------------
  // x0 is reset to zero and never written; the read mux also forces it to 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREGS; i++) r_data[i] <= '0;
    end else if (w_wr_valid) begin
      r_data[i_rd_addr] <= i_rd_data;
    end
  end

  // ---------------- pending counters ----------------
  assign w_cnt[0] = '0;
  assign w_inc[0] = 1'b0;
  assign w_dec[0] = 1'b0;
  assign w_nz[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_cnt
      // dec depends only on writeback inputs, so ready (which uses dec) does
      // not form a loop with inc (which uses ready).
      assign w_dec[gi] = i_rd_wren && (i_rd_addr == AW'(gi)) && (w_cnt[gi] != '0);
      assign w_inc[gi] = i_rsv_en && o_rsv_ready && !i_flush &&
                         (i_rsv_addr == AW'(gi));
      assign w_nz[gi]  = (w_cnt[gi] != '0);

      rf_pend_cnt #(
        .MAX_PEND (MAX_PEND),
        .CW       (CW)
      ) u_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_inc  (w_inc[gi]),
        .i_dec  (w_dec[gi]),
        .i_clr  (i_flush),
        .o_cnt  (w_cnt[gi])
      );
    end
  endgenerate

  // A full register still accepts a reservation when it retires one the same
  // cycle, since the counter then holds.
  assign o_rsv_ready = (i_rsv_addr == '0) ||
                       (w_cnt[i_rsv_addr] != CW'(MAX_PEND)) ||
                       w_dec[i_rsv_addr];

  assign o_any_busy = |w_nz;

  // ---------------- sticky scoreboard error ----------------
  assign w_underflow = w_wr_valid && (w_cnt[i_rd_addr] == '0) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sb_err <= 1'b0;
    end else if (w_underflow) begin
      r_sb_err <= 1'b1;
    end
  end

  assign o_sb_err = r_sb_err;

  // ---------------- read ports ----------------
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_rs;
      logic          w_hit;

      assign w_rs  = i_rs_addr[gi*AW +: AW];
      assign w_hit = BYPASS_EN && w_wr_valid && (i_rd_addr == w_rs);

      always_comb begin
        o_rs_data[gi*XLEN +: XLEN] = '0;
        o_rs_busy[gi]              = 1'b0;
        if (w_rs != '0) begin
          if (w_hit) begin
            // Same-cycle reservations are deliberately not reflected here.
            o_rs_data[gi*XLEN +: XLEN] = i_rd_data;
            o_rs_busy[gi] = (w_cnt[w_rs] - CW'(w_dec[w_rs])) != '0;
          end else begin
            o_rs_data[gi*XLEN +: XLEN] = r_data[w_rs];
            o_rs_busy[gi] = (w_cnt[w_rs] != '0);
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb. Two instances share all inputs:
// u_dut with bypass and u_nb without, so the bypass/no-bypass timing can be
// compared on the same stimulus.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_rd_wren;
  logic [AW-1:0]     i_rd_addr;
  logic [XLEN-1:0]   i_rd_data;
  logic              i_rsv_en;
  logic [AW-1:0]     i_rsv_addr;
  logic              i_flush;
  logic [AW-1:0]     rs0, rs1;
  logic [NRD*AW-1:0] i_rs_addr;

  logic              o_rsv_ready, nb_rsv_ready;
  logic [NRD*XLEN-1:0] o_rs_data, nb_rs_data;
  logic [NRD-1:0]    o_rs_busy, nb_rs_busy;
  logic              o_any_busy, nb_any_busy;
  logic              o_sb_err, nb_sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  assign i_rs_addr = {rs1, rs0};

  always #5 i_clk = ~i_clk;

  regfile_sb #(.BYPASS_EN(1'b1)) u_dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr), .o_rsv_ready(o_rsv_ready),
    .i_flush(i_flush), .i_rs_addr(i_rs_addr),
    .o_rs_data(o_rs_data), .o_rs_busy(o_rs_busy),
    .o_any_busy(o_any_busy), .o_sb_err(o_sb_err)
  );

  regfile_sb #(.BYPASS_EN(1'b0)) u_nb (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr), .o_rsv_ready(nb_rsv_ready),
    .i_flush(i_flush), .i_rs_addr(i_rs_addr),
    .o_rs_data(nb_rs_data), .o_rs_busy(nb_rs_busy),
    .o_any_busy(nb_any_busy), .o_sb_err(nb_sb_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs change here and
  // outputs are then sampled a few ns later, well away from either edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_rd_wren = 1'b0;
    i_rsv_en  = 1'b0;
    i_flush   = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    i_rstn = 1'b0;
    idle();
    i_rd_addr = '0; i_rd_data = '0; i_rsv_addr = '0;
    rs0 = 5'd0; rs1 = 5'd0;

    // ---------------- reset and x0 ----------------
    rs0 = 5'd5; rs1 = 5'd7;
    settle();
    check("rst_data",  64'(o_rs_data), 64'h0);
    check("rst_busy",  64'(o_rs_busy), 64'h0);
    check("rst_any",   64'(o_any_busy), 64'h0);
    check("rst_err",   64'(o_sb_err), 64'h0);
    check("rst_ready", 64'(o_rsv_ready), 64'h1);
    tick(); tick();
    i_rstn = 1'b1;
    tick();

    rs0 = 5'd0;
    i_rd_wren = 1'b1; i_rd_addr = 5'd0; i_rd_data = 32'hDEADBEEF;
    i_rsv_en = 1'b1;  i_rsv_addr = 5'd0;
    settle();
    check("x0_byp_data", 64'(o_rs_data[31:0]), 64'h0);
    check("x0_rsv_ready", 64'(o_rsv_ready), 64'h1);
    tick(); idle();
    settle();
    check("x0_data",  64'(o_rs_data[31:0]), 64'h0);
    check("x0_busy",  64'(o_rs_busy[0]), 64'h0);
    check("x0_any",   64'(o_any_busy), 64'h0);
    check("x0_err",   64'(o_sb_err), 64'h0);

    // ---------------- bypass ----------------
    i_rsv_en = 1'b1; i_rsv_addr = 5'd5;
    tick(); idle();
    rs0 = 5'd5;
    i_rd_wren = 1'b1; i_rd_addr = 5'd5; i_rd_data = 32'h12345678;
    settle();
    check("byp_data_same",   64'(o_rs_data[31:0]), 64'h12345678);
    check("byp_busy_same",   64'(o_rs_busy[0]), 64'h0);
    check("nobyp_data_old",  64'(nb_rs_data[31:0]), 64'h0);
    check("nobyp_busy_same", 64'(nb_rs_busy[0]), 64'h1);
    tick(); idle();
    settle();
    check("nobyp_data_next", 64'(nb_rs_data[31:0]), 64'h12345678);
    check("nobyp_busy_next", 64'(nb_rs_busy[0]), 64'h0);

    // ---------------- counter saturation on x7 ----------------
    rs1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      i_rsv_en = 1'b1; i_rsv_addr = 5'd7;
      settle();
      check($sformatf("sat_ready%0d", i), 64'(o_rsv_ready), 64'h1);
      if (i == 0) check("rsv_not_busy_same", 64'(o_rs_busy[1]), 64'h0);
      tick();
    end
    idle();
    settle();
    check("sat_busy", 64'(o_rs_busy[1]), 64'h1);
    i_rsv_en = 1'b1; i_rsv_addr = 5'd7;
    settle();
    check("sat_full_ready", 64'(o_rsv_ready), 64'h0);
    tick();
    // full register + same-cycle retire: accepted, count holds at 3
    i_rd_wren = 1'b1; i_rd_addr = 5'd7; i_rd_data = 32'h77;
    settle();
    check("sat_rsv_wb_ready", 64'(o_rsv_ready), 64'h1);
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      i_rd_wren = 1'b1; i_rd_addr = 5'd7; i_rd_data = 32'h70 + i;
      tick();
    end
    idle();
    settle();
    check("sat_busy_cnt1", 64'(o_rs_busy[1]), 64'h1);
    i_rd_wren = 1'b1; i_rd_addr = 5'd7; i_rd_data = 32'h7F;
    settle();
    check("sat_last_byp_busy", 64'(o_rs_busy[1]), 64'h0);
    check("sat_last_nb_busy",  64'(nb_rs_busy[1]), 64'h1);
    tick(); idle();
    settle();
    check("sat_idle_busy", 64'(o_rs_busy[1]), 64'h0);
    check("sat_idle_any",  64'(o_any_busy), 64'h0);
    check("sat_data",      64'(nb_rs_data[63:32]), 64'h7F);
    check("sat_err",       64'(o_sb_err), 64'h0);

    // ---------------- busy bypass on x3 ----------------
    i_rsv_en = 1'b1; i_rsv_addr = 5'd3;
    tick(); idle();
    rs0 = 5'd3;
    settle();
    check("bb_busy_before", 64'(o_rs_busy[0]), 64'h1);
    i_rd_wren = 1'b1; i_rd_addr = 5'd3; i_rd_data = 32'h0000A5A5;
    settle();
    check("bb_busy", 64'(o_rs_busy[0]), 64'h0);
    check("bb_data", 64'(o_rs_data[31:0]), 64'hA5A5);
    tick(); idle();

    // ---------------- flush ----------------
    i_rsv_en = 1'b1; i_rsv_addr = 5'd2; tick();
    tick();
    i_rsv_addr = 5'd9; tick();
    idle();
    rs0 = 5'd2; rs1 = 5'd9;
    settle();
    check("fl_busy_pre", 64'(o_rs_busy), 64'h3);
    i_flush = 1'b1; i_rsv_en = 1'b1; i_rsv_addr = 5'd4;
    tick(); idle();
    rs0 = 5'd4;
    settle();
    check("fl_any",    64'(o_any_busy), 64'h0);
    check("fl_nb_any", 64'(nb_any_busy), 64'h0);
    check("fl_x4",     64'(o_rs_busy[0]), 64'h0);
    check("fl_err",    64'(o_sb_err), 64'h0);

    // ---------------- underflow and mid-cycle reset ----------------
    i_rd_wren = 1'b1; i_rd_addr = 5'd10; i_rd_data = 32'h0000CAFE;
    tick(); idle();
    rs0 = 5'd10; rs1 = 5'd5;
    settle();
    check("uf_err",  64'(o_sb_err), 64'h1);
    check("uf_data", 64'(o_rs_data[31:0]), 64'hCAFE);
    check("uf_busy", 64'(o_rs_busy[0]), 64'h0);
    tick();
    settle();
    check("uf_sticky", 64'(o_sb_err), 64'h1);
    i_rstn = 1'b0;
    #1;
    check("mr_err",   64'(o_sb_err), 64'h0);
    check("mr_data0", 64'(o_rs_data[31:0]), 64'h0);
    check("mr_data1", 64'(o_rs_data[63:32]), 64'h0);
    check("mr_ready", 64'(o_rsv_ready), 64'h1);
    tick();
    i_rstn = 1'b1;
    tick();
    settle();
    check("post_rst_data", 64'(nb_rs_data[31:0]), 64'h0);
    check("post_rst_err",  64'(o_sb_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised scoreboarded register file: the next-generation GPR bank for the pipelined core. Provides NRD asynchronous read ports, one synchronous write port, optional write-through bypass, and a per-register pending-write counter that marks registers busy between issue (reservation) and writeback. It sits between decode/issue, which reserves destinations and checks operand hazards, and writeback, which retires results.

## Interface
- XLEN, 32, data width.
- NREGS, 32, register count; power of two, ≥ 2; AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- MAX_PEND, 3, maximum outstanding reservations per register; CW = $clog2(MAX_PEND+1).
- BYPASS_EN, 1, enables write-through of data and busy state to read ports.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_rd_wren  in  1  writeback enable.
- i_rd_addr  in  AW  writeback register.
- i_rd_data  in  XLEN  writeback data.
- i_rsv_en  in  1  reserve request; marks the destination pending.
- i_rsv_addr  in  AW  register to reserve.
- o_rsv_ready  out  1  reservation can be accepted this cycle.
- i_flush  in  1  clear all pending counters.
- i_rs_addr  in  NRD×AW  read addresses, packed; port k at [k*AW +: AW].
- o_rs_data  out  NRD×XLEN  read data, packed.
- o_rs_busy  out  NRD  operand has outstanding writes.
- o_any_busy  out  1  OR of all counters ≠ 0.
- o_sb_err  out  1  sticky: a scoreboarded writeback arrived while the counter was 0.

## Operation
- **Register x0:**
  - Reads return 0 and busy 0.
  - Writes are ignored.
  - Reservations of x0 are accepted (o_rsv_ready=1) and have no effect.
- **Write:** data register i_rd_addr ← i_rd_data on the edge when i_rd_wren=1 and addr≠0.
- **Pending counter cnt[r], per register:**
  - inc = i_rsv_en & o_rsv_ready & ~i_flush & (i_rsv_addr==r) & (r≠0).
  - dec = i_rd_wren & (i_rd_addr==r) & (cnt[r]≠0).
  - inc&dec: hold. inc only: +1. dec only: −1.
  - i_flush=1: all counters go to 0 regardless of inc/dec.
- **Ready:** o_rsv_ready = (i_rsv_addr==0) | (cnt[i_rsv_addr]≠MAX_PEND) | dec for that address. A request with o_rsv_ready=0 is dropped; the requester holds i_rsv_en until ready.
- **Underflow:** i_rd_wren to r≠0 with cnt[r]==0 and no flush:
  - The data write still occurs.
  - The counter stays 0.
  - o_sb_err sets at the next edge and stays set until reset.
- **Read, combinational:**
  - BYPASS_EN=1 and i_rd_wren & i_rd_addr==rs & rs≠0: data = i_rd_data; busy = (cnt[rs] − dec) ≠ 0.
  - Otherwise: data = stored value; busy = cnt[rs] ≠ 0.
  - Bypass never includes same-cycle inc; a same-cycle reservation does not make the operand busy.

## Timing
- Reset (asynchronous assert) clears all data registers to 0, all counters to 0, and o_sb_err to 0.
- Output values during and immediately after reset: o_rs_data=0, o_rs_busy=0, o_any_busy=0, o_sb_err=0, o_rsv_ready=1.
- Write-to-read latency: 0 cycles with BYPASS_EN=1; 1 cycle with BYPASS_EN=0.
- Reserve-to-busy latency: 1 cycle. Writeback-to-not-busy latency: 0 cycles with bypass, 1 cycle without.
- Flush-to-not-busy latency: 1 cycle. Writebacks in the flush cycle still update data.
- A reset asserted mid-operation discards all pending state with no completion.
- No combinational path from i_rsv_* to o_rs_*. o_rsv_ready depends combinationally on i_rsv_addr, i_rd_wren and i_rd_addr.

## Structure
- Package regfile_pkg: default constants XLEN_D=32, NREGS_D=32, MAX_PEND_D=3.
- Sub-module rf_pend_cnt: one CW-bit counter with inc, dec and clr inputs and saturation asserts. It is instantiated NREGS−1 times in a generate loop; x0 has none.
- The data bank is a flop array with per-register enable. Read ports are generated NRD times.

## Test plan
- **Reset and x0:** reset asserted, then write 0xDEADBEEF to x0 → all reads return 0, busy 0, o_rsv_ready=1.
- **Bypass:** BYPASS_EN=1, write x5=0x12345678 while rs0=x5 → o_rs_data[0]=0x12345678 the same cycle. With BYPASS_EN=0 → old value, new value the next cycle.
- **Counter saturation:** reserve x7 three times → o_rs_busy=1. A 4th request gives o_rsv_ready=0 and is dropped. Reserve plus writeback to x7 in the same cycle → accepted, cnt stays 3. Three writebacks → busy 0.
- **Busy bypass:** cnt[x3]=1, writeback x3 while reading x3 → busy 0 and new data the same cycle.
- **Flush:** cnt[x2]=2 and cnt[x9]=1, assert i_flush together with a reservation of x4 → next cycle o_any_busy=0 and x4 is not busy.
- **Underflow and mid-operation reset:** writeback to x10 with cnt 0 → data written, o_sb_err=1 sticky. Then async reset mid-cycle → o_sb_err=0 and data 0 immediately.
